// File: rtl/hight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hight_ctrl
// Purpose  : Host-side driver for the hight cipher core. Loads a 128-bit
//            master key, sequences the key schedule handshake, issues one
//            64-bit block at a time and buffers results in a 2-entry FIFO.
// Options  : HIGHT_CTRL_WDT_EN - enables a RUN-state watchdog that aborts a
//            block after WDT_CYCLES cycles without a core response.
// Revision : 1.0 - initial release
// ============================================================================
module hight_ctrl #(
  parameter int WDT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_key_valid,
  input  logic [127:0] s_key,
  output logic         s_key_ready,
  input  logic         s_valid,
  input  logic         s_op,
  input  logic [63:0]  s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [63:0]  m_data,
  input  logic         m_ready,
  output logic         key_ok,
  output logic         err,
  output logic         o_mk_rdy,
  output logic [127:0] o_mk,
  output logic         o_post_rdy,
  output logic         o_op,
  output logic         o_text_val,
  output logic [63:0]  o_text_in,
  input  logic         i_text_done,
  input  logic [63:0]  i_text_out,
  input  logic         i_rdy
);

  typedef enum logic [2:0] {
    NOKEY  = 3'd0,
    KSCHED = 3'd1,
    POST   = 3'd2,
    IDLE   = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t      state;
  logic        ks_first;   // first KSCHED cycle: core o_rdy not yet meaningful
  logic [1:0]  count;      // FIFO occupancy
  logic [63:0] tail;       // second FIFO entry (head lives in m_data)
  logic        key_acc;
  logic        blk_acc;
  logic        push;
  logic        pop;

`ifdef HIGHT_CTRL_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);
  logic [15:0] wdt_cnt;
`else
  logic wdt_unused;
  assign wdt_unused = (WDT_CYCLES > 0);
`endif

  // Handshake qualifiers; a pending key offer always wins over a block.
  assign s_key_ready = i_rdy && ((state == NOKEY) || (state == IDLE));
  assign s_ready     = (state == IDLE) && i_rdy && !s_key_valid && (count < 2'd2);
  assign key_acc     = s_key_valid && s_key_ready;
  assign blk_acc     = s_valid && s_ready;
  assign push        = (state == RUN) && i_text_done;
  assign pop         = m_valid && m_ready;
  assign m_valid     = (count != 2'd0);

  // Control FSM with registered core-facing outputs and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= NOKEY;
      ks_first   <= 1'b0;
      key_ok     <= 1'b0;
      err        <= 1'b0;
      o_mk_rdy   <= 1'b0;
      o_mk       <= '0;
      o_post_rdy <= 1'b0;
      o_op       <= 1'b0;
      o_text_val <= 1'b0;
      o_text_in  <= '0;
`ifdef HIGHT_CTRL_WDT_EN
      wdt_cnt    <= '0;
`endif
    end else begin
      o_mk_rdy   <= 1'b0;
      o_post_rdy <= 1'b0;
      o_text_val <= 1'b0;
      // A done outside RUN has no block to belong to: flag and discard.
      if (i_text_done && (state != RUN)) begin
        err <= 1'b1;
      end
      case (state)
        NOKEY, IDLE: begin
          if (key_acc) begin
            o_mk     <= s_key;
            o_mk_rdy <= 1'b1;
            key_ok   <= 1'b0;
            ks_first <= 1'b1;
            state    <= KSCHED;
          end else if (blk_acc) begin
            o_text_in  <= s_data;
            o_op       <= s_op;
            o_text_val <= 1'b1;
            state      <= RUN;
`ifdef HIGHT_CTRL_WDT_EN
            wdt_cnt    <= '0;
`endif
          end
        end
        KSCHED: begin
          ks_first <= 1'b0;
          if (!ks_first && i_rdy) begin
            o_post_rdy <= 1'b1;
            key_ok     <= 1'b1;
            state      <= POST;
          end
        end
        POST: begin
          state <= IDLE;
        end
        RUN: begin
          if (i_text_done) begin
            state <= IDLE;
`ifdef HIGHT_CTRL_WDT_EN
          end else if (wdt_cnt == WDT_LAST) begin
            // Core went silent: abandon the block and force a key reload.
            err    <= 1'b1;
            key_ok <= 1'b0;
            state  <= NOKEY;
          end else begin
            wdt_cnt <= wdt_cnt + 16'd1;
`endif
          end
        end
        default: begin
          state <= NOKEY;
        end
      endcase
    end
  end

  // Two-entry result FIFO; the head register drives m_data directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= 2'd0;
      m_data <= '0;
      tail   <= '0;
    end else begin
      if (push && pop) begin
        if (count == 2'd1) begin
          m_data <= i_text_out;
        end else begin
          m_data <= tail;
          tail   <= i_text_out;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          m_data <= i_text_out;
        end else begin
          tail <= i_text_out;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        if (count == 2'd2) begin
          m_data <= tail;
        end
        count <= count - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hight_ctrl
// Purpose  : Directed, table-driven bench for hight_ctrl. The core side is
//            driven directly from the vector table / hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hight_ctrl;

  localparam logic [127:0] KEY = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [63:0]  D1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0]  D2  = 64'h2222_2222_2222_2222;
  localparam logic [63:0]  D3  = 64'h3333_3333_3333_3333;
  localparam logic [63:0]  D4  = 64'h4444_4444_4444_4444;
  localparam logic [63:0]  R1  = 64'hA1A1_A1A1_0000_0001;
  localparam logic [63:0]  R2  = 64'hB2B2_B2B2_0000_0002;
  localparam logic [63:0]  R3  = 64'hC3C3_C3C3_0000_0003;
  localparam logic [63:0]  XX  = 64'hDEAD_BEEF_DEAD_BEEF;

  logic         clk = 1'b0;
  logic         rstn;
  logic         s_key_valid;
  logic [127:0] s_key;
  logic         s_key_ready;
  logic         s_valid;
  logic         s_op;
  logic [63:0]  s_data;
  logic         s_ready;
  logic         m_valid;
  logic [63:0]  m_data;
  logic         m_ready;
  logic         key_ok;
  logic         err;
  logic         o_mk_rdy;
  logic [127:0] o_mk;
  logic         o_post_rdy;
  logic         o_op;
  logic         o_text_val;
  logic [63:0]  o_text_in;
  logic         i_text_done;
  logic [63:0]  i_text_out;
  logic         i_rdy;

  int n_vec  = 0;
  int n_fail = 0;

  hight_ctrl #(.WDT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_key_valid(s_key_valid), .s_key(s_key), .s_key_ready(s_key_ready),
    .s_valid(s_valid), .s_op(s_op), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .key_ok(key_ok), .err(err),
    .o_mk_rdy(o_mk_rdy), .o_mk(o_mk), .o_post_rdy(o_post_rdy), .o_op(o_op),
    .o_text_val(o_text_val), .o_text_in(o_text_in),
    .i_text_done(i_text_done), .i_text_out(i_text_out), .i_rdy(i_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv, v, op;
    logic [63:0] data;
    logic        mr, rdy, done;
    logic [63:0] tout;
    logic        kr, sr, mv;
    logic [63:0] md;
    logic        kok, er, mkr, post, tv;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_key_valid = 1'b0; s_valid = 1'b0; s_op = 1'b0; s_data = '0;
    m_ready = 1'b0; i_text_done = 1'b0; i_text_out = '0;
  endtask

  task automatic load_key();
    bit seen;
    s_key_valid = 1'b1; i_rdy = 1'b1;
    #2 chk("reload_key_ready", s_key_ready, 1);
    edge1();
    s_key_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #2 if (key_ok === 1'b1) seen = 1'b1;
      edge1();
    end
    chk("reload_key_ok", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    s_key = KEY;
    rstn  = 1'b0;
    i_rdy = 1'b0;
    idle_inputs();

    //                 kv v op data mr rdy dn tout | kr sr mv md kok er mkr post tv
    vq.push_back('{1,0,0,'0,0,1,0,'0, 1,0,0,'0,0,0,0,0,0}); // 0 key accept in NOKEY
    vq.push_back('{0,0,0,'0,0,0,0,'0, 0,0,0,'0,0,0,1,0,0}); // 1 o_mk_rdy pulse
    vq.push_back('{0,0,0,'0,0,0,0,'0, 0,0,0,'0,0,0,0,0,0}); // 2 core busy
    vq.push_back('{0,0,0,'0,0,0,0,'0, 0,0,0,'0,0,0,0,0,0}); // 3
    vq.push_back('{0,0,0,'0,0,0,0,'0, 0,0,0,'0,0,0,0,0,0}); // 4
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,0,'0,0,0,0,0,0}); // 5 core ready sampled
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,0,'0,1,0,0,1,0}); // 6 POST pulse, key_ok
    vq.push_back('{0,0,0,'0,0,1,0,'0, 1,1,0,'0,1,0,0,0,0}); // 7 IDLE
    vq.push_back('{0,1,0,D1,0,1,0,'0, 1,1,0,'0,1,0,0,0,0}); // 8 block 1 accept
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,0,'0,1,0,0,0,1}); // 9 text_val
    vq.push_back('{0,0,0,'0,0,1,1,R1, 0,0,0,'0,1,0,0,0,0}); // 10 done
    vq.push_back('{0,1,1,D2,0,1,0,'0, 1,1,1,R1,1,0,0,0,0}); // 11 result, block 2
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,1,R1,1,0,0,0,1}); // 12
    vq.push_back('{0,0,0,'0,0,1,1,R2, 0,0,1,R1,1,0,0,0,0}); // 13 done 2
    vq.push_back('{0,1,0,D3,0,1,0,'0, 1,0,1,R1,1,0,0,0,0}); // 14 FIFO full
    vq.push_back('{0,1,0,D3,1,1,0,'0, 1,0,1,R1,1,0,0,0,0}); // 15 pop
    vq.push_back('{0,1,0,D3,0,1,0,'0, 1,1,1,R2,1,0,0,0,0}); // 16 ready again
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,1,R2,1,0,0,0,1}); // 17
    vq.push_back('{0,0,0,'0,1,1,1,R3, 0,0,1,R2,1,0,0,0,0}); // 18 push+pop
    vq.push_back('{0,0,0,'0,1,1,0,'0, 1,1,1,R3,1,0,0,0,0}); // 19 pop last
    vq.push_back('{0,0,0,'0,0,1,0,'0, 1,1,0,'0,1,0,0,0,0}); // 20 empty
    vq.push_back('{1,1,0,D4,0,1,0,'0, 1,0,0,'0,1,0,0,0,0}); // 21 key beats block
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,0,'0,0,0,1,0,0}); // 22 rdy ignored
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,0,'0,0,0,0,0,0}); // 23 rdy sampled
    vq.push_back('{0,0,0,'0,0,1,0,'0, 0,0,0,'0,1,0,0,1,0}); // 24 POST
    vq.push_back('{0,0,0,'0,0,1,1,XX, 1,1,0,'0,1,0,0,0,0}); // 25 stray done
    vq.push_back('{0,0,0,'0,0,1,0,'0, 1,1,0,'0,1,1,0,0,0}); // 26 err sticky

    // Reset state
    edge1();
    edge1();
    chk("rst_s_key_ready", s_key_ready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_key_ok", key_ok, 0);
    chk("rst_err", err, 0);
    chk("rst_o_mk_rdy", o_mk_rdy, 0);
    chk("rst_o_mk", o_mk, 0);
    chk("rst_o_post_rdy", o_post_rdy, 0);
    chk("rst_o_text_val", o_text_val, 0);
    chk("rst_o_text_in", o_text_in, 0);
    chk("rst_o_op", o_op, 0);
    rstn = 1'b1;

    foreach (vq[i]) begin
      s_key_valid = vq[i].kv;   s_valid = vq[i].v;   s_op = vq[i].op;
      s_data = vq[i].data;      m_ready = vq[i].mr;  i_rdy = vq[i].rdy;
      i_text_done = vq[i].done; i_text_out = vq[i].tout;
      #2;
      chk($sformatf("v%0d_s_key_ready", i), s_key_ready, vq[i].kr);
      chk($sformatf("v%0d_s_ready", i), s_ready, vq[i].sr);
      chk($sformatf("v%0d_m_valid", i), m_valid, vq[i].mv);
      if (vq[i].mv) chk($sformatf("v%0d_m_data", i), m_data, vq[i].md);
      chk($sformatf("v%0d_key_ok", i), key_ok, vq[i].kok);
      chk($sformatf("v%0d_err", i), err, vq[i].er);
      chk($sformatf("v%0d_o_mk_rdy", i), o_mk_rdy, vq[i].mkr);
      chk($sformatf("v%0d_o_post_rdy", i), o_post_rdy, vq[i].post);
      chk($sformatf("v%0d_o_text_val", i), o_text_val, vq[i].tv);
      edge1();
    end
    idle_inputs();
    chk("o_mk_value", o_mk, KEY);

    // Single block, 33-cycle core latency
    s_valid = 1'b1; s_data = 64'h0011223344556677; s_op = 1'b0;
    #2 chk("blk_s_ready", s_ready, 1);
    edge1();
    s_valid = 1'b0; s_data = '0;
    #2;
    chk("blk_text_val", o_text_val, 1);
    chk("blk_text_in", o_text_in, 64'h0011223344556677);
    chk("blk_op", o_op, 0);
    for (int k = 1; k < 33; k++) begin
      if (k > 1) #2;
      chk($sformatf("blk_wait%0d", k), {m_valid, s_ready, o_text_val}, (k == 1) ? 3'b001 : 3'b000);
      edge1();
    end
    i_text_done = 1'b1; i_text_out = 64'hF2034FD9AE18F400;
    edge1();
    i_text_done = 1'b0; i_text_out = '0;
    #2;
    chk("blk_m_valid", m_valid, 1);
    chk("blk_m_data", m_data, 64'hF2034FD9AE18F400);
    chk("blk_ready_again", s_ready, 1);
    edge1();

    // Reset in the middle of RUN with a result still buffered
    s_valid = 1'b1; s_data = 64'hCAFE;
    edge1();
    s_valid = 1'b0;
    rstn = 1'b0; i_rdy = 1'b0;
    #1;
    chk("mid_rst_outs", {s_key_ready, s_ready, m_valid, key_ok, err, o_mk_rdy, o_post_rdy, o_text_val, o_op}, 9'd0);
    chk("mid_rst_mk", o_mk, 0);
    chk("mid_rst_text_in", o_text_in, 0);
    chk("mid_rst_m_data", m_data, 0);
    edge1();
    rstn = 1'b1; i_rdy = 1'b1;
    i_text_done = 1'b1; i_text_out = XX;
    edge1();
    i_text_done = 1'b0;
    #2;
    chk("post_rst_stray_err", err, 1);
    chk("post_rst_fifo", m_valid, 0);
    edge1();

    // Fresh reset, key reload, then a block the core never answers
    rstn = 1'b0;
    edge1();
    rstn = 1'b1;
    load_key();
    s_valid = 1'b1; s_op = 1'b1; s_data = 64'h0123456789ABCDEF;
    edge1();
    s_valid = 1'b0; s_op = 1'b0; s_data = '0;
    #2;
    chk("wd_op", o_op, 1);
    chk("wd_text_in", o_text_in, 64'h0123456789ABCDEF);
`ifdef HIGHT_CTRL_WDT_EN
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) #2;
      chk($sformatf("wd_run%0d", k), {err, key_ok, s_ready}, 3'b010);
      edge1();
    end
    #2;
    chk("wd_err", err, 1);
    chk("wd_key_ok", key_ok, 0);
    chk("wd_nokey", {s_key_ready, s_ready}, 2'b10);
    edge1();
`else
    for (int k = 0; k < 100; k++) edge1();
    #2;
    chk("nowd_still_run", {s_key_ready, s_ready, key_ok, err}, 4'b0010);
    edge1();
    i_text_done = 1'b1; i_text_out = R3;
    edge1();
    i_text_done = 1'b0;
    #2;
    chk("nowd_result", {m_valid, m_data}, {1'b1, R3});
    edge1();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hight_ctrl.md
# hight_ctrl

Host-side driver for the `hight` cipher core; it is the initiator for the core's key-load, post-ready and text handshake. It accepts a 128-bit master key and a stream of 64-bit blocks over valid/ready, and sequences the core's key schedule. It issues one block at a time to the core and buffers results in a 2-entry output FIFO for a downstream consumer. It sits between the system datapath and the `hight` instance.

## Interface
- `WDT_CYCLES`, 64: cycles allowed in RUN before a timeout; range 2..65535; used only with the watchdog.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `s_key_valid` in 1: master key offered.
- `s_key` in 128: master key.
- `s_key_ready` out 1: key accepted when `s_key_valid && s_key_ready`.
- `s_valid` in 1: input block offered.
- `s_op` in 1: operation, 0 = encrypt, 1 = decrypt; passed to the core.
- `s_data` in 64: input block.
- `s_ready` out 1: block accepted when `s_valid && s_ready`.
- `m_valid` out 1: result available at FIFO head.
- `m_data` out 64: result at FIFO head.
- `m_ready` in 1: consumer pops the head.
- `key_ok` out 1: a key schedule has completed and is valid.
- `err` out 1: sticky error flag, cleared only by reset.
- `o_mk_rdy` out 1: to core `i_mk_rdy`.
- `o_mk` out 128: to core `i_mk`.
- `o_post_rdy` out 1: to core `i_post_rdy`.
- `o_op` out 1: to core `i_op`.
- `o_text_val` out 1: to core `i_text_val`.
- `o_text_in` out 64: to core `i_text_in`.
- `i_text_done` in 1: from core `o_text_done`.
- `i_text_out` in 64: from core `o_text_out`.
- `i_rdy` in 1: from core `o_rdy`.

## Operation
- FSM states: NOKEY, KSCHED, POST, IDLE, RUN.
- Reset:
  - state NOKEY.
  - All registered outputs are 0, including `o_mk` and `o_text_in`.
  - FIFO is empty; `key_ok` = 0; `err` = 0.
- Key accept:
  - `s_key_ready` = `i_rdy` when the state is NOKEY or IDLE; 0 in all other states.
  - On accept, register `s_key` into `o_mk`, pulse `o_mk_rdy` for exactly 1 cycle, clear `key_ok`, go to KSCHED.
- KSCHED:
  - `i_rdy` is ignored in the first cycle.
  - From the second cycle on, `i_rdy` = 1 moves to POST.
- POST: pulse `o_post_rdy` for exactly 1 cycle, set `key_ok` = 1, go to IDLE.
- Block accept:
  - `s_ready` = (state IDLE) && `i_rdy` && `!s_key_valid` && (FIFO count + 0 in flight < 2).
  - A key offer therefore takes priority over a block offered in the same cycle.
  - On accept, register `s_data`/`s_op` into `o_text_in`/`o_op`, pulse `o_text_val` for 1 cycle, go to RUN.
- RUN:
  - On `i_text_done` = 1, push `i_text_out` into the FIFO and go to IDLE.
  - `o_text_in` and `o_op` hold their values until the next accept.
- FIFO:
  - Depth 2; `m_data` is registered.
  - Pop when `m_valid && m_ready`.
  - A push and a pop in the same cycle are both performed and the count is unchanged.
  - A push is never attempted while the FIFO is full, because `s_ready` is gated by space.
- Stray done: `i_text_done` in any state other than RUN sets `err`; the data is discarded and the state is unchanged.
- `err` never blocks operation.

## Timing
- Key: accept at cycle K; `o_mk_rdy` is high during K+1; `o_post_rdy` is high 1 cycle after `i_rdy` is sampled high (no earlier than K+3); `key_ok` rises with `o_post_rdy`.
- Block: accept at cycle A; `o_text_val` is high during A+1.
- Result: `i_text_done` sampled high at cycle D gives `m_valid` = 1 at D+1 (if the FIFO was empty).
- `s_ready` can re-assert at D+1.
- Throughput: one block in flight at any time.
- Reset asserted mid-operation: immediate return to reset values; in-flight block and FIFO contents are lost.

## Configuration
- `HIGHT_CTRL_WDT_EN` defined:
  - A 16-bit counter runs in RUN, cleared on entry to RUN.
  - If `WDT_CYCLES` cycles elapse without `i_text_done`: set `err`, drop the block, clear `key_ok`, go to NOKEY (a key reload is required).
  - `i_text_done` arriving in the same cycle as the timeout wins, and no error is raised.
- Not defined: no counter; RUN waits indefinitely; `WDT_CYCLES` is unused.

## Test plan
- Key load: reset, `i_rdy` = 1, key 0x00112233_44556677_8899AABB_CCDDEEFF -> `o_mk_rdy` 1-cycle pulse carrying the key; core holds `i_rdy` low for 4 cycles; `o_post_rdy` pulses once; `key_ok` = 1.
- Single block: `s_data` 0x0011223344556677, `s_op` = 0; model core returns 0xF2034FD9AE18F400 after 33 cycles -> `o_text_val` pulse at A+1; `m_valid`/`m_data` = 0xF2034FD9AE18F400 at D+1.
- Backpressure: `m_ready` = 0, three blocks offered -> two results buffered, `s_ready` stays 0 for the third; one pop re-enables `s_ready` the next cycle.
- Priority: `s_key_valid` and `s_valid` both asserted in IDLE -> key accepted, block not accepted, `key_ok` drops until POST.
- Errors: `i_text_done` pulsed in IDLE -> `err` = 1, FIFO unchanged.
  - With `HIGHT_CTRL_WDT_EN` and `WDT_CYCLES` = 8, core silent -> `err` = 1 after 8 cycles in RUN, state NOKEY, `key_ok` = 0.
- Reset mid-RUN: `rstn` low for 1 cycle -> all outputs 0, FIFO empty, a subsequent stray `i_text_done` sets `err`.
